// File: rtl/rca_lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rca_lsu_arbiter
//  Purpose  : Front end for the load/store unit's RCA port. It collects memory
//             requests from NUM_PORTS accelerator ports and arbitrates between
//             them round-robin. It acquires the LSU through the lock handshake
//             and issues at most one request per cycle. In-order load results
//             are routed back to the port that issued the load. The lock is
//             released once traffic has drained.
//
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             port_req/load/store  - per-port request valid and kind
//             port_addr/wdata/fn3  - per-port request fields (packed, port i
//                                    occupies slice i)
//             port_ack             - one-hot, request accepted this cycle
//             port_rvalid/rdata    - one-hot load return, shared data bus
//             rca_lsu_lock         - LSU ownership request/hold
//             rca_rs1/rs2/fn3      - address, store data, size code to LSU
//             rca_load/rca_store   - issue strobes to LSU
//             lsu_ready            - LSU serving RCA and able to accept
//             lsu_rvalid/rdata     - in-order load result from LSU
//             busy                 - arbiter not idle
//             stat_*               - activity counters (only with the macro
//                                    RCA_LSU_ARB_STATS_EN defined)
//
//  Revision : 1.0 - initial release
// ============================================================================
module rca_lsu_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RELEASE_DELAY   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      port_req,
    input  logic [NUM_PORTS-1:0]      port_load,
    input  logic [NUM_PORTS-1:0]      port_store,
    input  logic [NUM_PORTS*32-1:0]   port_addr,
    input  logic [NUM_PORTS*32-1:0]   port_wdata,
    input  logic [NUM_PORTS*3-1:0]    port_fn3,
    output logic [NUM_PORTS-1:0]      port_ack,
    output logic [NUM_PORTS-1:0]      port_rvalid,
    output logic [31:0]               port_rdata,
    output logic                      rca_lsu_lock,
    output logic [31:0]               rca_rs1,
    output logic [31:0]               rca_rs2,
    output logic [2:0]                rca_fn3,
    output logic                      rca_load,
    output logic                      rca_store,
    input  logic                      lsu_ready,
    input  logic                      lsu_rvalid,
    input  logic [31:0]               lsu_rdata,
`ifdef RCA_LSU_ARB_STATS_EN
    output logic [31:0]               stat_loads,
    output logic [31:0]               stat_stores,
    output logic [31:0]               stat_stall_cycles,
`endif
    output logic                      busy
);

    localparam int c_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_AW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = c_AW + 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACQUIRE = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN   = 2'd3;

    localparam logic [NUM_PORTS-1:0] c_ONE       = NUM_PORTS'(1);
    localparam logic [4:0]           c_REL_DELAY = 5'(RELEASE_DELAY);
    localparam logic [c_CNT_W-1:0]   c_FIFO_FULL = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_AW-1:0]      c_PTR_LAST  = c_AW'(MAX_OUTSTANDING - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_IDX_W-1:0]  r_rr;
    logic [3:0]          r_rel_cnt;

    logic [c_IDX_W-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [31:0]         r_rs1;
    logic [31:0]         r_rs2;
    logic [2:0]          r_fn3;
    logic [NUM_PORTS-1:0] r_port_rvalid;
    logic [31:0]         r_port_rdata;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_load_block;
    logic [NUM_PORTS-1:0] w_elig;
    logic                w_grant_valid;
    logic [c_IDX_W-1:0]  w_grant_idx;
    logic [31:0]         w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic [2:0]          w_sel_fn3;
    logic                w_sel_store;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_any_req;
    logic                w_rel_expired;

    // (base + off) mod NUM_PORTS, with off < NUM_PORTS
    function automatic logic [c_IDX_W-1:0] f_wrap(input logic [c_IDX_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return s[c_IDX_W-1:0];
    endfunction

    assign w_any_req    = |port_req;
    assign w_fifo_full  = (r_count == c_FIFO_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = lsu_rvalid & ~w_fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO only blocks loads
    // when no result is returning.
    assign w_load_block = w_fifo_full & ~lsu_rvalid;

    // A port asserting both strobes counts as a store, so it is never blocked
    // by the FIFO. Load-only ports are masked while the FIFO cannot accept,
    // letting the rotation fall through to the next eligible port.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_elig[i] = port_req[i] & (port_store[i] | (port_load[i] & ~w_load_block));
        end
    end

    // Round-robin search starting at r_rr. Scanning from the far end means the
    // last hit is the closest port to the pointer.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_elig[f_wrap(r_rr, k)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = f_wrap(r_rr, k);
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_fn3   = '0;
        w_sel_store = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant_idx == i[c_IDX_W-1:0]) begin
                w_sel_addr  = port_addr[i*32 +: 32];
                w_sel_wdata = port_wdata[i*32 +: 32];
                w_sel_fn3   = port_fn3[i*3 +: 3];
                w_sel_store = port_store[i];
            end
        end
    end

    assign w_issue = (r_state == c_ST_ACTIVE) & lsu_ready & w_grant_valid;
    assign w_push  = w_issue & ~w_sel_store;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign port_ack     = w_issue ? (c_ONE << w_grant_idx) : '0;
    assign rca_load     = w_issue & ~w_sel_store;
    assign rca_store    = w_issue & w_sel_store;
    // Data fields follow the granted port in an issue cycle and otherwise
    // hold the last issued values.
    assign rca_rs1      = w_issue ? w_sel_addr  : r_rs1;
    assign rca_rs2      = w_issue ? w_sel_wdata : r_rs2;
    assign rca_fn3      = w_issue ? w_sel_fn3   : r_fn3;
    assign rca_lsu_lock = (r_state != c_ST_IDLE);
    assign busy         = (r_state != c_ST_IDLE);
    assign port_rvalid  = r_port_rvalid;
    assign port_rdata   = r_port_rdata;

    // ------------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------------
    // The idle counter has seen RELEASE_DELAY quiet cycles including this one.
    assign w_rel_expired = (({1'b0, r_rel_cnt} + 5'd1) >= c_REL_DELAY);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) w_state_nxt = c_ST_ACQUIRE;
            end
            c_ST_ACQUIRE: begin
                if (lsu_ready) w_state_nxt = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if (!w_any_req && w_rel_expired) w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (w_any_req)                       w_state_nxt = c_ST_ACTIVE;
                else if (w_fifo_empty && !lsu_rvalid) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_rel_cnt <= '0;
            r_rr      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_ST_ACTIVE) && !w_any_req && !w_rel_expired)
                r_rel_cnt <= r_rel_cnt + 4'd1;
            else
                r_rel_cnt <= '0;
            if (w_issue)
                r_rr <= f_wrap(w_grant_idx, 1);
        end
    end

    // ------------------------------------------------------------------------
    // Held request fields
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_fn3 <= '0;
        end else if (w_issue) begin
            r_rs1 <= w_sel_addr;
            r_rs2 <= w_sel_wdata;
            r_fn3 <= w_sel_fn3;
        end
    end

    // ------------------------------------------------------------------------
    // Return-routing FIFO: one port index per outstanding load
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_grant_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_AW'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - c_CNT_W'(1);
        end
    end

    // Returns are registered: one cycle from lsu_rvalid to port_rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_rvalid <= '0;
            r_port_rdata  <= '0;
        end else begin
            r_port_rvalid <= w_pop ? (c_ONE << r_fifo[r_rd_ptr]) : '0;
            if (w_pop) r_port_rdata <= lsu_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Optional activity counters (saturating)
    // ------------------------------------------------------------------------
`ifdef RCA_LSU_ARB_STATS_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = (r_state == c_ST_ACTIVE) & w_any_req & ~w_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (rca_load && (r_stat_loads != 32'hFFFF_FFFF))
                r_stat_loads <= r_stat_loads + 32'd1;
            if (rca_store && (r_stat_stores != 32'hFFFF_FFFF))
                r_stat_stores <= r_stat_stores + 32'd1;
            if (w_stall && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_loads        = r_stat_loads;
    assign stat_stores       = r_stat_stores;
    assign stat_stall_cycles = r_stat_stall;
`endif

    // ------------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------------
    // A result with nothing outstanding is dropped; flag it without stopping.
    a_rvalid_empty: assert property (@(posedge clk) disable iff (rst)
        !(lsu_rvalid && w_fifo_empty))
        else $warning("rca_lsu_arbiter: lsu_rvalid with no outstanding load ignored");

    // Request fields must not change while a request waits for its ack.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stable
            a_hold: assert property (@(posedge clk) disable iff (rst)
                (port_req[gi] && !port_ack[gi]) |=>
                (!port_req[gi] || $stable({port_load[gi], port_store[gi],
                                           port_addr[gi*32 +: 32],
                                           port_wdata[gi*32 +: 32],
                                           port_fn3[gi*3 +: 3]})))
                else $error("rca_lsu_arbiter: port %0d changed fields before ack", gi);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rca_lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rca_lsu_arbiter
//  Purpose  : Directed self-checking bench for rca_lsu_arbiter (default
//             parameters). A cycle table covers round-robin stores, a single
//             load with its return, and return ordering. Hand sequences cover
//             the FIFO-full case, reset in DRAIN and, when
//             RCA_LSU_ARB_STATS_EN is defined, the activity counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rca_lsu_arbiter;

    localparam logic [31:0] c_A0 = 32'h1000_0000;
    localparam logic [31:0] c_A1 = 32'h1000_0010;
    localparam logic [31:0] c_A2 = 32'h8000_1004;
    localparam logic [31:0] c_A3 = 32'h1000_0030;
    localparam logic [31:0] c_W1 = 32'hA0A0_0001;
    localparam logic [3:0]  c_F  = 4'hF;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   port_req, port_load, port_store;
    logic [127:0] port_addr, port_wdata;
    logic [11:0]  port_fn3;
    logic [3:0]   port_ack, port_rvalid;
    logic [31:0]  port_rdata;
    logic         rca_lsu_lock;
    logic [31:0]  rca_rs1, rca_rs2;
    logic [2:0]   rca_fn3;
    logic         rca_load, rca_store;
    logic         lsu_ready, lsu_rvalid;
    logic [31:0]  lsu_rdata;
    logic         busy;
`ifdef RCA_LSU_ARB_STATS_EN
    logic [31:0]  stat_loads, stat_stores, stat_stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    rca_lsu_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .port_req     (port_req),
        .port_load    (port_load),
        .port_store   (port_store),
        .port_addr    (port_addr),
        .port_wdata   (port_wdata),
        .port_fn3     (port_fn3),
        .port_ack     (port_ack),
        .port_rvalid  (port_rvalid),
        .port_rdata   (port_rdata),
        .rca_lsu_lock (rca_lsu_lock),
        .rca_rs1      (rca_rs1),
        .rca_rs2      (rca_rs2),
        .rca_fn3      (rca_fn3),
        .rca_load     (rca_load),
        .rca_store    (rca_store),
        .lsu_ready    (lsu_ready),
        .lsu_rvalid   (lsu_rvalid),
        .lsu_rdata    (lsu_rdata),
`ifdef RCA_LSU_ARB_STATS_EN
        .stat_loads        (stat_loads),
        .stat_stores       (stat_stores),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req, ld, st;
        logic        rdy, rv;
        logic [31:0] rdata;
        logic [3:0]  e_ack, e_rv;
        logic        e_lock, e_ld, e_st;
        logic [31:0] e_rs1, e_rdata;
        logic [2:0]  e_fn3;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] req, ld, st, input logic rdy, rv,
                                input logic [31:0] rdata, input logic [3:0] e_ack, e_rv,
                                input logic e_lock, e_ld, e_st,
                                input logic [31:0] e_rs1, e_rdata);
        vec_t v;
        v.req = req; v.ld = ld; v.st = st; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.e_ack = e_ack; v.e_rv = e_rv; v.e_lock = e_lock; v.e_ld = e_ld; v.e_st = e_st;
        v.e_rs1 = e_rs1; v.e_rdata = e_rdata;
        // port i uses fn3 = i, so the held fn3 follows the held address
        case (e_rs1)
            c_A1:    v.e_fn3 = 3'd1;
            c_A2:    v.e_fn3 = 3'd2;
            c_A3:    v.e_fn3 = 3'd3;
            default: v.e_fn3 = 3'd0;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rq, ld, st, input logic rdy, rv,
                         input logic [31:0] rd);
        port_req = rq; port_load = ld; port_store = st;
        lsu_ready = rdy; lsu_rvalid = rv; lsu_rdata = rd;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        #3;
        while (busy && n < 20) begin
            next_cycle();
            #3;
            n++;
        end
        check({name, ".idle"}, 32'(busy), 32'd0);
        next_cycle();
    endtask

    initial begin
        rst        = 1'b1;
        port_addr  = {c_A3, c_A2, c_A1, c_A0};
        port_wdata = {32'hA0A0_0003, 32'hA0A0_0002, c_W1, 32'hA0A0_0000};
        port_fn3   = {3'd3, 3'd2, 3'd1, 3'd0};
        drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0);

        // ---------------- table: RR stores, single load, return order -------
        // round-robin: all ports store
        vecs.push_back(mk(c_F,0,c_F,1,0,0,    4'h0,4'h0,0,0,0, 32'h0,0));   // IDLE
        vecs.push_back(mk(c_F,0,c_F,1,0,0,    4'h0,4'h0,1,0,0, 32'h0,0));   // ACQUIRE
        vecs.push_back(mk(c_F,0,c_F,1,0,0,    4'h1,4'h0,1,0,1, c_A0,0));
        vecs.push_back(mk(c_F,0,c_F,1,0,0,    4'h2,4'h0,1,0,1, c_A1,0));
        vecs.push_back(mk(c_F,0,c_F,1,0,0,    4'h4,4'h0,1,0,1, c_A2,0));
        vecs.push_back(mk(c_F,0,c_F,1,0,0,    4'h8,4'h0,1,0,1, c_A3,0));
        vecs.push_back(mk(c_F,0,c_F,1,0,0,    4'h1,4'h0,1,0,1, c_A0,0));
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h0,1,0,0, c_A0,0));    // quiet 1
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h0,1,0,0, c_A0,0));    // quiet 2
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h0,1,0,0, c_A0,0));    // DRAIN
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h0,0,0,0, c_A0,0));    // IDLE
        // single load from port 2, ready 3 cycles after lock
        vecs.push_back(mk(4'h4,4'h4,0,0,0,0,  4'h0,4'h0,0,0,0, c_A0,0));
        vecs.push_back(mk(4'h4,4'h4,0,0,0,0,  4'h0,4'h0,1,0,0, c_A0,0));
        vecs.push_back(mk(4'h4,4'h4,0,0,0,0,  4'h0,4'h0,1,0,0, c_A0,0));
        vecs.push_back(mk(4'h4,4'h4,0,0,0,0,  4'h0,4'h0,1,0,0, c_A0,0));
        vecs.push_back(mk(4'h4,4'h4,0,1,0,0,  4'h0,4'h0,1,0,0, c_A0,0));    // ready seen
        vecs.push_back(mk(4'h4,4'h4,0,1,0,0,  4'h4,4'h0,1,1,0, c_A2,0));    // issue
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h0,1,0,0, c_A2,0));
        vecs.push_back(mk(0,0,0,1,1,32'hDEADBEEF, 4'h0,4'h0,1,0,0, c_A2,0));
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h4,1,0,0, c_A2,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h0,0,0,0, c_A2,32'hDEADBEEF));
        // return ordering: port 3 then port 1
        vecs.push_back(mk(4'hA,4'hA,0,1,0,0,  4'h0,4'h0,0,0,0, c_A2,32'hDEADBEEF));
        vecs.push_back(mk(4'hA,4'hA,0,1,0,0,  4'h0,4'h0,1,0,0, c_A2,32'hDEADBEEF));
        vecs.push_back(mk(4'hA,4'hA,0,1,0,0,  4'h8,4'h0,1,1,0, c_A3,32'hDEADBEEF));
        vecs.push_back(mk(4'h2,4'h2,0,1,0,0,  4'h2,4'h0,1,1,0, c_A1,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,1,1,32'h11,   4'h0,4'h0,1,0,0, c_A1,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,1,1,32'h22,   4'h0,4'h8,1,0,0, c_A1,32'h11));
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h2,1,0,0, c_A1,32'h22));
        vecs.push_back(mk(0,0,0,1,0,0,        4'h0,4'h0,0,0,0, c_A1,32'h22));

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #4;
        check("reset.lock",   32'(rca_lsu_lock), 32'd0);
        check("reset.busy",   32'(busy),         32'd0);
        check("reset.ack",    32'(port_ack),     32'd0);
        check("reset.rvalid", 32'(port_rvalid),  32'd0);
        check("reset.rdata",  port_rdata,        32'd0);
        check("reset.rs1",    rca_rs1,           32'd0);
        check("reset.strobe", 32'({rca_load, rca_store}), 32'd0);
        next_cycle();
        rst = 1'b0;

        foreach (vecs[n]) begin
            drive(vecs[n].req, vecs[n].ld, vecs[n].st, vecs[n].rdy, vecs[n].rv, vecs[n].rdata);
            #3;
            check($sformatf("v%0d.ack", n),    32'(port_ack),     32'(vecs[n].e_ack));
            check($sformatf("v%0d.rvalid", n), 32'(port_rvalid),  32'(vecs[n].e_rv));
            check($sformatf("v%0d.lock", n),   32'(rca_lsu_lock), 32'(vecs[n].e_lock));
            check($sformatf("v%0d.busy", n),   32'(busy),         32'(vecs[n].e_lock));
            check($sformatf("v%0d.load", n),   32'(rca_load),     32'(vecs[n].e_ld));
            check($sformatf("v%0d.store", n),  32'(rca_store),    32'(vecs[n].e_st));
            check($sformatf("v%0d.rs1", n),    rca_rs1,           vecs[n].e_rs1);
            check($sformatf("v%0d.fn3", n),    32'(rca_fn3),      32'(vecs[n].e_fn3));
            check($sformatf("v%0d.rdata", n),  port_rdata,        vecs[n].e_rdata);
            next_cycle();
        end

        // ---------------- FIFO full: 5 loads from port 0 ----------------
        drive(4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 32'h0);
        #3; next_cycle();                              // IDLE
        #3; next_cycle();                              // ACQUIRE
        for (int n = 0; n < 4; n++) begin
            #3; check($sformatf("full.ack%0d", n), 32'(port_ack), 32'h1);
            next_cycle();
        end
        #3; check("full.blocked", 32'(port_ack), 32'h0);
        next_cycle();
        drive(4'h3, 4'h1, 4'h2, 1'b1, 1'b0, 32'h0);    // store on port 1 while full
        #3;
        check("full.store_ack", 32'(port_ack),  32'h2);
        check("full.store_stb", 32'(rca_store), 32'h1);
        check("full.store_rs2", rca_rs2,        c_W1);
        check("full.store_fn3", 32'(rca_fn3),   32'h1);
        next_cycle();
        drive(4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 32'h0);
        #3; check("full.blocked2", 32'(port_ack), 32'h0);
        next_cycle();
        drive(4'h1, 4'h1, 4'h0, 1'b1, 1'b1, 32'h100);  // first return frees a slot
        #3; check("full.ack_on_pop", 32'(port_ack), 32'h1);
        next_cycle();
        for (int n = 0; n < 4; n++) begin
            drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 32'h101 + 32'(n));
            #3;
            check($sformatf("full.ret%0d.rv", n), 32'(port_rvalid), 32'h1);
            check($sformatf("full.ret%0d.d", n),  port_rdata, 32'h100 + 32'(n));
            next_cycle();
        end
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #3;
        check("full.ret4.rv", 32'(port_rvalid), 32'h1);
        check("full.ret4.d",  port_rdata,       32'h104);
        next_cycle();
        wait_idle("full");

        // ---------------- reset in DRAIN with 2 loads outstanding ---------
        drive(4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 32'h0);
        #3; next_cycle();                              // IDLE
        #3; next_cycle();                              // ACQUIRE
        #3; check("rst.ack0", 32'(port_ack), 32'h1); next_cycle();
        #3; check("rst.ack1", 32'(port_ack), 32'h1); next_cycle();
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #3; next_cycle();                              // quiet 1
        #3; next_cycle();                              // quiet 2 -> DRAIN
        #3;
        check("rst.drain_lock", 32'(rca_lsu_lock), 32'h1);
        check("rst.drain_busy", 32'(busy),         32'h1);
        next_cycle();
        rst = 1'b1;
        #3; next_cycle();
        rst = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 32'h55);   // stale LSU result
        #3;
        check("rst.lock", 32'(rca_lsu_lock), 32'h0);
        check("rst.busy", 32'(busy),         32'h0);
        next_cycle();
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #3;
        check("rst.stale_rv", 32'(port_rvalid), 32'h0);
        check("rst.stale_d",  port_rdata,       32'h0);
        next_cycle();
        // pointer back to 0 after reset
        drive(c_F, 4'h0, c_F, 1'b1, 1'b0, 32'h0);
        #3; next_cycle();                              // IDLE
        #3; next_cycle();                              // ACQUIRE
        #3; check("rst.rr0", 32'(port_ack), 32'h1); next_cycle();
        #3; check("rst.rr1", 32'(port_ack), 32'h2); next_cycle();
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        wait_idle("rst");

`ifdef RCA_LSU_ARB_STATS_EN
        // ---------------- counters: 3 loads, 2 stores, 4 stalls -----------
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0);
        #3; next_cycle();                              // IDLE
        drive(4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 32'h0);
        #3; next_cycle();                              // ACQUIRE
        drive(4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0);
        repeat (4) begin #3; next_cycle(); end         // stalled
        drive(4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 32'h0);
        repeat (3) begin #3; next_cycle(); end         // loads
        drive(4'h2, 4'h0, 4'h2, 1'b1, 1'b0, 32'h0);
        repeat (2) begin #3; next_cycle(); end         // stores
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #3;
        check("stat.loads",  stat_loads,        32'd3);
        check("stat.stores", stat_stores,       32'd2);
        check("stat.stall",  stat_stall_cycles, 32'd4);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
